// File: rtl/house_score_sequencer_if.sv
// Score-sequencer bus: start handshake, the four house scores, status, ranking and the digit read port.
interface house_score_sequencer_if #(
  parameter int SCORE_W = 20
);
  logic               start;
  logic [SCORE_W-1:0] g_score;
  logic [SCORE_W-1:0] s_score;
  logic [SCORE_W-1:0] r_score;
  logic [SCORE_W-1:0] h_score;
  logic               busy;
  logic               done;
  logic               ready;
  logic [7:0]         rank_order;
  logic [1:0]         rd_house;
  logic [2:0]         rd_digit;
  logic [3:0]         rd_bcd;

  modport master (
    output start, g_score, s_score, r_score, h_score, rd_house, rd_digit,
    input  busy, done, ready, rank_order, rd_bcd
  );

  modport slave (
    input  start, g_score, s_score, r_score, h_score, rd_house, rd_digit,
    output busy, done, ready, rank_order, rd_bcd
  );
endinterface

// File: rtl/house_score_sequencer.sv
// Latches four house scores, converts each to BCD with a serial double-dabble, ranks them and serves digits.
// Optional macro LEADING_ZERO_BLANK_EN: leading zero digits read back as 4'hF (blank glyph).
module house_score_sequencer #(
  parameter int SCORE_W = 20,
  parameter int DIGITS  = 6,
  parameter int SAT_MAX = 999999
) (
  input  logic                 clk,
  input  logic                 resetn,
  house_score_sequencer_if.slave bus
);

  localparam int DDW = 4 * DIGITS + SCORE_W;
  localparam int CW  = $clog2(SCORE_W);
  localparam logic [SCORE_W-1:0] SAT_V = SCORE_W'(SAT_MAX);

  typedef enum logic [2:0] {IDLE, LOAD, CONVERT, STORE, RANK, DONE} state_t;

  state_t             state_q;
  logic               busy_q;
  logic               done_q;
  logic               ready_q;
  logic [7:0]         rankOrder_q;
  logic [3:0]         rdBcd_q;
  logic [SCORE_W-1:0] score_q [4];
  logic [DDW-1:0]     dd_q;
  logic [DDW-1:0]     ddAdj;
  logic [DDW-1:0]     ddNext;
  logic [CW-1:0]      bitCnt_q;
  logic [1:0]         house_q;
  logic [2:0]         rankStep_q;
  logic [1:0]         rkId_q [4];
  logic [1:0]         rkIdSw [4];
  logic [SCORE_W-1:0] rkScore_q [4];
  logic [SCORE_W-1:0] rkScoreSw [4];
  logic [1:0]         idxA;
  logic [1:0]         idxB;
  logic [3:0]         digit_q [4][DIGITS];
  logic [2:0]         rdIdx;
  logic [3:0]         rdVal;

  function automatic logic [SCORE_W-1:0] clampScore(input logic [SCORE_W-1:0] s);
    return (s > SAT_V) ? SAT_V : s;
  endfunction

  always_comb begin
    ddAdj = dd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (dd_q[SCORE_W+4*i +: 4] >= 4'd5) begin
        ddAdj[SCORE_W+4*i +: 4] = dd_q[SCORE_W+4*i +: 4] + 4'd3;
      end
    end
    ddNext = {ddAdj[DDW-2:0], 1'b0};
  end

  // One compare-swap of the ranking network per cycle; equal scores order by lower house id.
  always_comb begin
    idxA = 2'd1;
    idxB = 2'd2;
    case (rankStep_q)
      3'd0:    begin idxA = 2'd0; idxB = 2'd1; end
      3'd1:    begin idxA = 2'd2; idxB = 2'd3; end
      3'd2:    begin idxA = 2'd0; idxB = 2'd2; end
      3'd3:    begin idxA = 2'd1; idxB = 2'd3; end
      default: begin idxA = 2'd1; idxB = 2'd2; end
    endcase
    rkIdSw    = rkId_q;
    rkScoreSw = rkScore_q;
    if ((rkScore_q[idxB] > rkScore_q[idxA]) ||
        ((rkScore_q[idxB] == rkScore_q[idxA]) && (rkId_q[idxB] < rkId_q[idxA]))) begin
      rkIdSw[idxA]    = rkId_q[idxB];
      rkIdSw[idxB]    = rkId_q[idxA];
      rkScoreSw[idxA] = rkScore_q[idxB];
      rkScoreSw[idxB] = rkScore_q[idxA];
    end
  end

  always_comb begin
    rdIdx = '0;
    rdVal = '0;
    if ((bus.rd_digit >= 3'd1) && (bus.rd_digit <= 3'd6)) begin
      rdIdx = bus.rd_digit - 3'd1;
      rdVal = digit_q[bus.rd_house][rdIdx];
`ifdef LEADING_ZERO_BLANK_EN
      begin
        logic aboveNz;
        aboveNz = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
          if ((k >= int'(rdIdx)) && (digit_q[bus.rd_house][k] != 4'd0)) aboveNz = 1'b1;
        end
        if ((rdIdx != 3'd0) && !aboveNz) rdVal = 4'hF;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b0;
      rankOrder_q <= 8'b00_01_10_11;
      rdBcd_q     <= '0;
      dd_q        <= '0;
      bitCnt_q    <= '0;
      house_q     <= '0;
      rankStep_q  <= '0;
      for (int h = 0; h < 4; h++) begin
        score_q[h]   <= '0;
        rkScore_q[h] <= '0;
        rkId_q[h]    <= 2'(h);
        for (int d = 0; d < DIGITS; d++) digit_q[h][d] <= '0;
      end
    end else begin
      done_q  <= 1'b0;
      rdBcd_q <= rdVal;
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        LOAD: begin
          score_q[0]   <= clampScore(bus.g_score);
          score_q[1]   <= clampScore(bus.s_score);
          score_q[2]   <= clampScore(bus.r_score);
          score_q[3]   <= clampScore(bus.h_score);
          rkScore_q[0] <= clampScore(bus.g_score);
          rkScore_q[1] <= clampScore(bus.s_score);
          rkScore_q[2] <= clampScore(bus.r_score);
          rkScore_q[3] <= clampScore(bus.h_score);
          for (int h = 0; h < 4; h++) rkId_q[h] <= 2'(h);
          dd_q     <= {{(4*DIGITS){1'b0}}, clampScore(bus.g_score)};
          house_q  <= '0;
          bitCnt_q <= '0;
          state_q  <= CONVERT;
        end
        CONVERT: begin
          dd_q     <= ddNext;
          bitCnt_q <= bitCnt_q + 1'b1;
          if (bitCnt_q == CW'(SCORE_W - 1)) begin
            bitCnt_q <= '0;
            state_q  <= STORE;
          end
        end
        STORE: begin
          for (int d = 0; d < DIGITS; d++) digit_q[house_q][d] <= dd_q[SCORE_W+4*d +: 4];
          if (house_q == 2'd3) begin
            rankStep_q <= '0;
            state_q    <= RANK;
          end else begin
            house_q <= house_q + 2'd1;
            dd_q    <= {{(4*DIGITS){1'b0}}, score_q[house_q + 2'd1]};
            state_q <= CONVERT;
          end
        end
        RANK: begin
          rkId_q     <= rkIdSw;
          rkScore_q  <= rkScoreSw;
          rankStep_q <= rankStep_q + 3'd1;
          if (rankStep_q == 3'd5) begin
            rankOrder_q <= {rkIdSw[0], rkIdSw[1], rkIdSw[2], rkIdSw[3]};
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.ready      = ready_q;
  assign bus.rank_order = rankOrder_q;
  assign bus.rd_bcd     = rdBcd_q;

endmodule

// File: tb/tb_house_score_sequencer.sv
// Self-checking bench for house_score_sequencer: table vectors, random runs and multi-cycle corner sequences.
module tb_house_score_sequencer;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  house_score_sequencer_if #(.SCORE_W(20)) bus ();

  house_score_sequencer #(
    .SCORE_W(20),
    .DIGITS (6),
    .SAT_MAX(999999)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  typedef struct {
    logic [19:0] g;
    logic [19:0] s;
    logic [19:0] r;
    logic [19:0] h;
    logic [7:0]  rank;
  } vec_t;

  int          errCount   = 0;
  int          checkCount = 0;
  logic [19:0] lastScores [4];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int clampScore(input logic [19:0] s);
    return (int'(s) > 999999) ? 999999 : int'(s);
  endfunction

  // Decimal digit of the clamped score; code 1 is the ones digit.
  function automatic logic [3:0] expDigit(input logic [19:0] s, input int code);
    int sc;
    int p;
    sc = clampScore(s);
    if (code < 1 || code > 6) return 4'd0;
    p = 1;
    for (int i = 1; i < code; i++) p = p * 10;
`ifdef LEADING_ZERO_BLANK_EN
    if (code > 1 && sc < p) return 4'hF;
`endif
    return 4'((sc / p) % 10);
  endfunction

  // A house's place is the number of houses that beat it (higher score, or equal score and lower id).
  function automatic logic [7:0] expRank(input logic [19:0] sc [4]);
    logic [7:0] r;
    int pos;
    r = '0;
    for (int h = 0; h < 4; h++) begin
      pos = 0;
      for (int o = 0; o < 4; o++) begin
        if (o != h && (clampScore(sc[o]) > clampScore(sc[h]) ||
            (clampScore(sc[o]) == clampScore(sc[h]) && o < h))) pos++;
      end
      r[7-2*pos -: 2] = 2'(h);
    end
    return r;
  endfunction

  task automatic readDigit(input int house, input int code, output logic [3:0] val);
    bus.rd_house = 2'(house);
    bus.rd_digit = 3'(code);
    @(posedge clk);
    #1;
    val = bus.rd_bcd;
  endtask

  task automatic checkDigits(input string tag);
    logic [3:0] v;
    for (int h = 0; h < 4; h++) begin
      for (int c = 0; c < 8; c++) begin
        readDigit(h, c, v);
        checkOutput($sformatf("%s digit h%0d c%0d", tag, h, c), 32'(v), 32'(expDigit(lastScores[h], c)));
      end
    end
  endtask

  // Starts a conversion and returns at the cycle done is seen (or after the budget runs out).
  task automatic applyStimulus(input logic [19:0] g, input logic [19:0] s, input logic [19:0] r,
                               input logic [19:0] h, input int restartAt, output int lat);
    int n;
    lastScores = '{g, s, r, h};
    bus.g_score = g;
    bus.s_score = s;
    bus.r_score = r;
    bus.h_score = h;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checkOutput("busy after start", 32'(bus.busy), 32'd1);
    checkOutput("ready cleared on start", 32'(bus.ready), 32'd0);
    @(posedge clk);
    #1;
    n = 1;
    bus.g_score = 20'($urandom);
    bus.s_score = 20'($urandom);
    bus.r_score = 20'($urandom);
    bus.h_score = 20'($urandom);
    while (!bus.done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      bus.start = (n == restartAt);
    end
    bus.start = 1'b0;
    lat = n;
  endtask

  task automatic checkAfterDone(input string tag, input int lat, input logic [7:0] rank, input bit advance);
    checkOutput({tag, " latency"}, 32'(lat), 32'd91);
    checkOutput({tag, " done"}, 32'(bus.done), 32'd1);
    checkOutput({tag, " busy low"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, " ready"}, 32'(bus.ready), 32'd1);
    checkOutput({tag, " rank_order"}, 32'(bus.rank_order), 32'(rank));
    if (advance) begin
      @(posedge clk);
      #1;
      checkOutput({tag, " done one cycle"}, 32'(bus.done), 32'd0);
    end
  endtask

  vec_t vecs [8];

  initial begin
    int         lat;
    logic [19:0] rs [4];

    vecs[0] = '{20'd1234,    20'd56789,   20'd0,      20'd999999,  8'b11_01_00_10};
    vecs[1] = '{20'd1234,    20'd56789,   20'd0,      20'd1048575, 8'b11_01_00_10};
    vecs[2] = '{20'd500,     20'd500,     20'd500,    20'd500,     8'b00_01_10_11};
    vecs[3] = '{20'd0,       20'd0,       20'd0,      20'd0,       8'b00_01_10_11};
    vecs[4] = '{20'd10,      20'd20,      20'd30,     20'd40,      8'b11_10_01_00};
    vecs[5] = '{20'd999999,  20'd1048575, 20'd999999, 20'd5,       8'b00_01_10_11};
    vecs[6] = '{20'd7,       20'd100000,  20'd100000, 20'd6,       8'b01_10_00_11};
    vecs[7] = '{20'd40,      20'd0,       20'd3,      20'd1000000, 8'b11_00_10_01};

    resetn       = 1'b0;
    bus.start    = 1'b0;
    bus.g_score  = '0;
    bus.s_score  = '0;
    bus.r_score  = '0;
    bus.h_score  = '0;
    bus.rd_house = '0;
    bus.rd_digit = 3'd1;
    #12;
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset done", 32'(bus.done), 32'd0);
    checkOutput("reset ready", 32'(bus.ready), 32'd0);
    checkOutput("reset rank_order", 32'(bus.rank_order), 32'h1B);
    checkOutput("reset rd_bcd", 32'(bus.rd_bcd), 32'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].g, vecs[i].s, vecs[i].r, vecs[i].h, -1, lat);
      checkAfterDone($sformatf("vec%0d", i), lat, vecs[i].rank, 1'b1);
      checkDigits($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 5; i++) begin
      rs[0] = 20'($urandom);
      rs[1] = 20'($urandom_range(0, 999999));
      rs[2] = (i == 2) ? rs[1] : 20'($urandom_range(0, 2000));
      rs[3] = 20'($urandom);
      applyStimulus(rs[0], rs[1], rs[2], rs[3], -1, lat);
      checkAfterDone($sformatf("rand%0d", i), lat, expRank(lastScores), 1'b1);
      checkDigits($sformatf("rand%0d", i));
    end

    applyStimulus(20'd111111, 20'd222222, 20'd333333, 20'd444444, 30, lat);
    checkAfterDone("restart ignored", lat, expRank(lastScores), 1'b1);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("restart no second done", 32'(bus.done), 32'd0);
    checkOutput("restart stays idle", 32'(bus.busy), 32'd0);
    checkDigits("restart");

    applyStimulus(20'd42, 20'd7, 20'd900000, 20'd13, -1, lat);
    checkAfterDone("b2b first", lat, expRank(lastScores), 1'b0);
    applyStimulus(20'd5, 20'd6, 20'd7, 20'd8, -1, lat);
    checkAfterDone("b2b second", lat, 8'b11_10_01_00, 1'b1);
    checkDigits("b2b");

    lastScores = '{20'd9, 20'd99, 20'd999, 20'd9999};
    bus.g_score = lastScores[0];
    bus.s_score = lastScores[1];
    bus.r_score = lastScores[2];
    bus.h_score = lastScores[3];
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (40) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("midreset busy", 32'(bus.busy), 32'd0);
    checkOutput("midreset ready", 32'(bus.ready), 32'd0);
    checkOutput("midreset done", 32'(bus.done), 32'd0);
    checkOutput("midreset rank_order", 32'(bus.rank_order), 32'h1B);
    checkOutput("midreset rd_bcd", 32'(bus.rd_bcd), 32'd0);
    #5;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    lastScores = '{20'd0, 20'd0, 20'd0, 20'd0};
    checkDigits("midreset file");
    applyStimulus(20'd314159, 20'd271828, 20'd161803, 20'd141421, -1, lat);
    checkAfterDone("after midreset", lat, 8'b00_01_10_11, 1'b1);
    checkDigits("after midreset");

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
